if_fetch_fsm: RTL

Instruction fetch unit for the NES 6502 core: the responder side of the IF/IE handshake. On a start pulse from the execute FSM it reads the opcode and operand bytes at the supplied PC and resolves the addressing mode to an effective address, immediate value or branch target. It then presents the decoded instruction with `if_ready` high. Its memory port is muxed onto the shared CPU bus at top level while `mem_rd_active` is high.

---
 rtl/if_fetch_fsm_pkg.sv | 23 ++
 rtl/if_fetch_fsm_if.sv | 29 ++
 rtl/if_fetch_fsm_mode_decode.sv | 96 +++++++++
 rtl/if_fetch_fsm.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_fsm_pkg.sv
// rtl/if_fetch_fsm_pkg.sv - shared types for the 6502 instruction fetch unit
package if_defs;

  typedef enum logic [3:0] {
    M_IMP, M_ACC, M_IMM, M_ZP, M_ZPX, M_ZPY, M_ABS,
    M_ABSX, M_ABSY, M_IND, M_INDX, M_INDY, M_REL
  } if_mode_e;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_OP, S_FETCH_LO, S_FETCH_HI, S_PTR_LO, S_PTR_HI, S_RESOLVE
  } if_state_e;

  localparam logic [7:0] OP_JMP_IND = 8'h6C;

  function automatic logic [1:0] mode_len(input if_mode_e m);
    case (m)
      M_IMP, M_ACC:                   mode_len = 2'd1;
      M_ABS, M_ABSX, M_ABSY, M_IND:   mode_len = 2'd3;
      default:                        mode_len = 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/if_fetch_fsm_if.sv
// rtl/if_fetch_fsm_if.sv - IF/IE handshake and read-only bus port of the fetch unit
interface if_fetch_fsm_if;
  logic        if_start;
  logic [15:0] pc_in;
  logic [7:0]  x;
  logic [7:0]  y;
  logic [7:0]  mem_data_in;
  logic [15:0] mem_addr;
  logic        mem_rd_active;
  logic        if_ready;
  logic [7:0]  opcode;
  logic [15:0] if_addr_out;
  logic [15:0] if_pc_next;
  logic        immediate_flag;
  logic        page_cross;
  logic        illegal_op;

  modport master (
    output if_start, pc_in, x, y, mem_data_in,
    input  mem_addr, mem_rd_active, if_ready, opcode, if_addr_out,
           if_pc_next, immediate_flag, page_cross, illegal_op
  );

  modport slave (
    input  if_start, pc_in, x, y, mem_data_in,
    output mem_addr, mem_rd_active, if_ready, opcode, if_addr_out,
           if_pc_next, immediate_flag, page_cross, illegal_op
  );
endinterface

// File: rtl/if_fetch_fsm_mode_decode.sv
// rtl/if_fetch_fsm_mode_decode.sv - opcode to addressing mode, length and illegal flag
module if_fetch_mode_decode
  import if_defs::*;
(
  input  logic [7:0] i_opcode,
  output if_mode_e   o_mode,
  output logic [1:0] o_len,
  output logic       o_illegal
);

  logic [2:0] w_aaa;
  logic [2:0] w_bbb;
  logic [1:0] w_cc;

  assign w_aaa = i_opcode[7:5];
  assign w_bbb = i_opcode[4:2];
  assign w_cc  = i_opcode[1:0];

  // Decoded along the aaa/bbb/cc opcode grid; holes in the grid are illegal.
  always_comb begin
    o_mode    = M_IMP;
    o_illegal = 1'b0;
    if (i_opcode == OP_JMP_IND) begin
      o_mode = M_IND;
    end else begin
      case (w_cc)
        2'b01: begin
          case (w_bbb)
            3'd0:    o_mode = M_INDX;
            3'd1:    o_mode = M_ZP;
            3'd2:    o_mode = M_IMM;
            3'd3:    o_mode = M_ABS;
            3'd4:    o_mode = M_INDY;
            3'd5:    o_mode = M_ZPX;
            3'd6:    o_mode = M_ABSY;
            default: o_mode = M_ABSX;
          endcase
          if (i_opcode == 8'h89) o_illegal = 1'b1;
        end
        2'b10: begin
          case (w_bbb)
            3'd0: begin
              if (w_aaa == 3'd5) o_mode = M_IMM;
              else o_illegal = 1'b1;
            end
            3'd1: o_mode = M_ZP;
            3'd2: o_mode = (w_aaa < 3'd4) ? M_ACC : M_IMP;
            3'd3: o_mode = M_ABS;
            3'd4: o_illegal = 1'b1;
            3'd5: o_mode = (w_aaa == 3'd4 || w_aaa == 3'd5) ? M_ZPY : M_ZPX;
            3'd6: begin
              if (w_aaa != 3'd4 && w_aaa != 3'd5) o_illegal = 1'b1;
            end
            default: begin
              if (w_aaa == 3'd4) o_illegal = 1'b1;
              else if (w_aaa == 3'd5) o_mode = M_ABSY;
              else o_mode = M_ABSX;
            end
          endcase
        end
        2'b00: begin
          case (w_bbb)
            3'd0: begin
              if (w_aaa == 3'd1) o_mode = M_ABS;
              else if (w_aaa >= 3'd5) o_mode = M_IMM;
              else if (w_aaa == 3'd4) o_illegal = 1'b1;
            end
            3'd1: begin
              if (w_aaa == 3'd1 || w_aaa >= 3'd4) o_mode = M_ZP;
              else o_illegal = 1'b1;
            end
            3'd2: o_mode = M_IMP;
            3'd3: begin
              if (w_aaa == 3'd0) o_illegal = 1'b1;
              else o_mode = M_ABS;
            end
            3'd4: o_mode = M_REL;
            3'd5: begin
              if (w_aaa == 3'd4 || w_aaa == 3'd5) o_mode = M_ZPX;
              else o_illegal = 1'b1;
            end
            3'd6: o_mode = M_IMP;
            default: begin
              if (w_aaa == 3'd5) o_mode = M_ABSX;
              else o_illegal = 1'b1;
            end
          endcase
        end
        default: o_illegal = 1'b1;
      endcase
    end
    if (o_illegal) o_mode = M_IMP;
    o_len = mode_len(o_mode);
  end

endmodule

// File: rtl/if_fetch_fsm.sv
// rtl/if_fetch_fsm.sv - 6502 instruction fetch/address resolve FSM (IE responder side)
// Optional macro IF_JMP_IND_BUG_EN: JMP (ind) high pointer byte wraps within its page.
module if_fetch_fsm
  import if_defs::*;
(
  input  logic          clk,
  input  logic          rst,
  if_fetch_fsm_if.slave bus
);

  if_state_e   r_state;
  logic [1:0]  r_cnt;
  logic [15:0] r_pc;
  logic [7:0]  r_op;
  logic [7:0]  r_lo;
  logic [7:0]  r_hi;
  logic [7:0]  r_plo;
  logic [7:0]  r_phi;
  logic [15:0] r_mem_addr;
  logic        r_rd_active;
  logic        r_ready;
  logic [7:0]  r_opcode;
  logic [15:0] r_addr_out;
  logic [15:0] r_pc_next;
  logic        r_imm;
  logic        r_cross;
  logic        r_illegal;

  if_mode_e    w_mode;
  logic [1:0]  w_len;
  logic        w_illegal;
  logic        w_capture;
  logic        w_last;
  logic [7:0]  w_zpx;
  logic [7:0]  w_zpy;
  logic [7:0]  w_addr_lo_inc;
  logic [15:0] w_abs;
  logic [15:0] w_ptr;
  logic [15:0] w_absx;
  logic [15:0] w_absy;
  logic [15:0] w_ptry;
  logic [15:0] w_pc_next;
  logic [15:0] w_rel;
  logic [15:0] w_ptr_lo_addr;
  logic [15:0] w_ptr_hi_addr;
  logic [15:0] w_addr;
  logic        w_imm;
  logic        w_cross;

  if_fetch_mode_decode u_decode (
    .i_opcode  (r_op),
    .o_mode    (w_mode),
    .o_len     (w_len),
    .o_illegal (w_illegal)
  );

  // Bus data is sampled two edges after the address, the third cycle advances the FSM.
  assign w_capture     = (r_cnt == 2'd1);
  assign w_last        = (r_cnt == 2'd2);
  assign w_zpx         = r_lo + bus.x;
  assign w_zpy         = r_lo + bus.y;
  assign w_addr_lo_inc = r_mem_addr[7:0] + 8'd1;
  assign w_abs         = {r_hi, r_lo};
  assign w_ptr         = {r_phi, r_plo};
  assign w_absx        = w_abs + {8'h00, bus.x};
  assign w_absy        = w_abs + {8'h00, bus.y};
  assign w_ptry        = w_ptr + {8'h00, bus.y};
  assign w_pc_next     = r_pc + {14'd0, w_len};
  assign w_rel         = w_pc_next + {{8{r_lo[7]}}, r_lo};

  always_comb begin
    w_ptr_lo_addr = w_abs;
    if (w_mode == M_INDX) w_ptr_lo_addr = {8'h00, w_zpx};
    else if (w_mode == M_INDY) w_ptr_lo_addr = {8'h00, r_lo};
  end

  // Zero-page pointers always wrap in page 0; only JMP (ind) may carry.
`ifdef IF_JMP_IND_BUG_EN
  assign w_ptr_hi_addr = {r_mem_addr[15:8], w_addr_lo_inc};
`else
  assign w_ptr_hi_addr = (w_mode == M_IND) ? (r_mem_addr + 16'd1)
                                           : {r_mem_addr[15:8], w_addr_lo_inc};
`endif

  always_comb begin
    w_addr  = 16'h0000;
    w_imm   = 1'b0;
    w_cross = 1'b0;
    case (w_mode)
      M_IMM: begin
        w_addr = {8'h00, r_lo};
        w_imm  = 1'b1;
      end
      M_ZP:  w_addr = {8'h00, r_lo};
      M_ZPX: w_addr = {8'h00, w_zpx};
      M_ZPY: w_addr = {8'h00, w_zpy};
      M_ABS: w_addr = w_abs;
      M_ABSX: begin
        w_addr  = w_absx;
        w_cross = (w_absx[15:8] != r_hi);
      end
      M_ABSY: begin
        w_addr  = w_absy;
        w_cross = (w_absy[15:8] != r_hi);
      end
      M_REL: begin
        w_addr  = w_rel;
        w_cross = (w_rel[15:8] != w_pc_next[15:8]);
      end
      M_IND, M_INDX: w_addr = w_ptr;
      M_INDY: begin
        w_addr  = w_ptry;
        w_cross = (w_ptry[15:8] != r_phi);
      end
      default: w_addr = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 2'd0;
      r_pc        <= 16'h0000;
      r_op        <= 8'h00;
      r_lo        <= 8'h00;
      r_hi        <= 8'h00;
      r_plo       <= 8'h00;
      r_phi       <= 8'h00;
      r_mem_addr  <= 16'h0000;
      r_rd_active <= 1'b0;
      r_ready     <= 1'b0;
      r_opcode    <= 8'h00;
      r_addr_out  <= 16'h0000;
      r_pc_next   <= 16'h0000;
      r_imm       <= 1'b0;
      r_cross     <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      if (r_state != S_IDLE && r_state != S_RESOLVE)
        r_cnt <= w_last ? 2'd0 : r_cnt + 2'd1;
      case (r_state)
        S_IDLE: begin
          if (bus.if_start) begin
            r_pc        <= bus.pc_in;
            r_mem_addr  <= bus.pc_in;
            r_rd_active <= 1'b1;
            r_ready     <= 1'b0;
            r_state     <= S_FETCH_OP;
          end
        end
        S_FETCH_OP: begin
          if (w_capture) r_op <= bus.mem_data_in;
          if (w_last) begin
            if (w_len == 2'd1) begin
              r_rd_active <= 1'b0;
              r_state     <= S_RESOLVE;
            end else begin
              r_mem_addr <= r_pc + 16'd1;
              r_state    <= S_FETCH_LO;
            end
          end
        end
        S_FETCH_LO: begin
          if (w_capture) r_lo <= bus.mem_data_in;
          if (w_last) begin
            if (w_len == 2'd3) begin
              r_mem_addr <= r_pc + 16'd2;
              r_state    <= S_FETCH_HI;
            end else if (w_mode == M_INDX || w_mode == M_INDY) begin
              r_mem_addr <= w_ptr_lo_addr;
              r_state    <= S_PTR_LO;
            end else begin
              r_rd_active <= 1'b0;
              r_state     <= S_RESOLVE;
            end
          end
        end
        S_FETCH_HI: begin
          if (w_capture) r_hi <= bus.mem_data_in;
          if (w_last) begin
            if (w_mode == M_IND) begin
              r_mem_addr <= w_ptr_lo_addr;
              r_state    <= S_PTR_LO;
            end else begin
              r_rd_active <= 1'b0;
              r_state     <= S_RESOLVE;
            end
          end
        end
        S_PTR_LO: begin
          if (w_capture) r_plo <= bus.mem_data_in;
          if (w_last) begin
            r_mem_addr <= w_ptr_hi_addr;
            r_state    <= S_PTR_HI;
          end
        end
        S_PTR_HI: begin
          if (w_capture) r_phi <= bus.mem_data_in;
          if (w_last) begin
            r_rd_active <= 1'b0;
            r_state     <= S_RESOLVE;
          end
        end
        S_RESOLVE: begin
          r_ready    <= 1'b1;
          r_opcode   <= r_op;
          r_addr_out <= w_addr;
          r_pc_next  <= w_pc_next;
          r_imm      <= w_imm;
          r_cross    <= w_cross;
          r_illegal  <= w_illegal;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_addr       = r_mem_addr;
  assign bus.mem_rd_active  = r_rd_active;
  assign bus.if_ready       = r_ready;
  assign bus.opcode         = r_opcode;
  assign bus.if_addr_out    = r_addr_out;
  assign bus.if_pc_next     = r_pc_next;
  assign bus.immediate_flag = r_imm;
  assign bus.page_cross     = r_cross;
  assign bus.illegal_op     = r_illegal;

endmodule
